sram_rmw_ctrl: RTL and testbench

Byte-enable read-modify-write front end placed directly upstream of the `sram` wrapper. The underlying 16-bit-slice macros have no byte-write capability, so this block ignores nothing: it converts every partial-byte write into an SRAM read followed by a merged full-word write. Reads and full-word writes pass straight through. It presents a single-outstanding req/gnt/rvalid port to the cache/memory client and drives the `sram` instance's req/we/addr/wdata, consuming its rdata.

---
 rtl/sram_rmw_pkg.sv | 19 +
 rtl/sram_rmw_ctrl_if.sv | 26 ++
 rtl/sram_be_merge.sv | 13 +
 rtl/sram_rmw_ctrl.sv | 121 ++++++++++++
 tb/tb_sram_rmw_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_rmw_pkg.sv
// Shared types and helpers for the SRAM read-modify-write front end.
package sram_rmw_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } rmw_state_e;

  localparam int unsigned RMW_CNT_WIDTH = 32;

  // Widest byte-enable vector be_full() accepts; callers pad unused upper bits with ones.
  localparam int unsigned MAX_BE_WIDTH = 64;

  // True when every byte lane is enabled.
  function automatic logic be_full(input logic [MAX_BE_WIDTH-1:0] be);
    return &be;
  endfunction

endpackage

// File: rtl/sram_rmw_ctrl_if.sv
// Client-side req/gnt/rvalid bus of the RMW front end.
interface sram_rmw_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024
) ();
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS);

  logic                    req;
  logic                    gnt;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/sram_be_merge.sv
// Combinational byte-lane merge: enabled lanes from the new word, others from the old word.
module sram_be_merge #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   merged
);
  for (genvar i = 0; i < DATA_WIDTH / 8; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end
endmodule

// File: rtl/sram_rmw_ctrl.sv
// Byte-enable RMW front end: partial writes become an SRAM read plus a merged full-word write.
module sram_rmw_ctrl
  import sram_rmw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  sram_rmw_ctrl_if.slave               bus,
  output logic                         sram_req_o,
  output logic                         sram_we_o,
  output logic [$clog2(NUM_WORDS)-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]        sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]        sram_rdata_i,
  output logic [RMW_CNT_WIDTH-1:0]     rmw_cnt_o
);
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS);
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

  localparam logic [0:0] StIdle  = IDLE;
  localparam logic [0:0] StMerge = MERGE;

  logic [0:0]               state_q, state_d;
  logic                     rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [BE_WIDTH-1:0]      be_q;
  logic [RMW_CNT_WIDTH-1:0] cnt_q;
  logic                     capture;
  logic [DATA_WIDTH-1:0]    merged;
  logic [MAX_BE_WIDTH-1:0]  be_pad;
  logic                     be_all, be_none;

  // Unused upper lanes read as enabled so the AND-reduction only sees real lanes.
  always_comb begin
    be_pad              = '1;
    be_pad[BE_WIDTH-1:0] = bus.be;
  end

  assign be_all  = be_full(be_pad);
  assign be_none = ~|bus.be;

  sram_be_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_merge (
    .old_word (sram_rdata_i),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  // Command decode and SRAM drive; outputs stay zero when nothing is issued.
  always_comb begin
    state_d      = state_q;
    rvalid_d     = 1'b0;
    capture      = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    case (state_q)
      StIdle: begin
        if (bus.req) begin
          if (!bus.we) begin
            sram_req_o  = 1'b1;
            sram_addr_o = bus.addr;
            rvalid_d    = 1'b1;
          end else if (be_all) begin
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = bus.addr;
            sram_wdata_o = bus.wdata;
          end else if (!be_none) begin
            // Fetch the old word; the merge happens next cycle.
            sram_req_o  = 1'b1;
            sram_addr_o = bus.addr;
            capture     = 1'b1;
            state_d     = StMerge;
          end
        end
      end
      StMerge: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = addr_q;
        sram_wdata_o = merged;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, read flag, captured command and saturating RMW counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rvalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      if (capture) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        be_q    <= bus.be;
      end
      if (state_q == StMerge && cnt_q != '1) begin
        cnt_q <= cnt_q + {{(RMW_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.gnt    = (state_q == StIdle);
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rvalid_q ? sram_rdata_i : '0;
  assign rmw_cnt_o  = cnt_q;
endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Scoreboard bench for sram_rmw_ctrl with a behavioural SRAM and a word-level memory model.
module tb_sram_rmw_ctrl;
  localparam int unsigned DW = 64;
  localparam int unsigned NW = 1024;
  localparam int unsigned AW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [31:0]   rmw_cnt;

  sram_rmw_ctrl_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

  sram_rmw_ctrl #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata),
    .rmw_cnt_o    (rmw_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: one-cycle read latency, no byte writes.
  logic [DW-1:0] sram_mem [NW];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Reference model: memory contents as seen in command-acceptance order.
  logic [DW-1:0] ref_mem [NW];
  logic [DW-1:0] rd_q [$];
  wr_t           wr_q [$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            exp_reqs = 0;
  int            act_reqs = 0;
  logic [31:0]   exp_cnt = 0;
  logic          exp_busy = 1'b0;

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT writes the SRAM or returns read data.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_req) act_reqs++;
      if (sram_req && sram_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_sram_write", 1'b1, 1'b0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("sram_write_addr", DW'(sram_addr), DW'(w.addr));
          chk("sram_write_data", sram_wdata, w.data);
        end
      end
      if (bus.rvalid) begin
        if (rd_q.size() == 0) chk("unexpected_rvalid", 1'b1, 1'b0);
        else                  chk("read_data", bus.rdata, rd_q.pop_front());
      end else begin
        chk("rdata_zero_when_idle", bus.rdata, '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk("gnt", DW'(bus.gnt), DW'(!exp_busy));
    exp_busy = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.req = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic void model_accept(input logic we, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d, input logic [7:0] be);
    logic [DW-1:0] m;
    if (!we) begin
      rd_q.push_back(ref_mem[a]);
      exp_reqs++;
    end else if (be == 8'hFF) begin
      ref_mem[a] = d;
      wr_q.push_back('{addr: a, data: d});
      exp_reqs++;
    end else if (be != 8'h00) begin
      m = ref_mem[a];
      for (int b = 0; b < 8; b++) if (be[b]) m[8*b +: 8] = d[8*b +: 8];
      ref_mem[a] = m;
      wr_q.push_back('{addr: a, data: m});
      exp_reqs += 2;
      if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      exp_busy = 1'b1;
    end
  endfunction

  // Present a command and hold it until granted (bounded).
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [7:0] be);
    bit done = 0;
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = a;
    bus.wdata = d;
    bus.be    = be;
    for (int g = 0; g < 3 && !done; g++) begin
      if (bus.gnt) begin
        model_accept(we, a, d, be);
        done = 1;
      end
      step();
    end
    bus.req = 1'b0;
    if (!done) chk("grant_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old40;
    for (int i = 0; i < NW; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    sram_rdata = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", DW'(bus.gnt), 1);
    chk("reset_rvalid", DW'(bus.rvalid), 0);
    chk("reset_cnt", DW'(rmw_cnt), 0);
    chk("reset_sram_req", DW'(sram_req), 0);
    rst_n = 1'b1;
    idle(2);

    // Full write then back-to-back read
    issue(1'b1, 10'h010, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    issue(1'b0, 10'h010, '0, 8'h00);
    idle(2);
    chk("cnt_after_full_write", DW'(rmw_cnt), 0);

    // Partial write merges into a preloaded word
    issue(1'b1, 10'h020, 64'h1111_2222_3333_4444, 8'hFF);
    issue(1'b1, 10'h020, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
    issue(1'b0, 10'h020, '0, 8'h00);
    idle(2);
    chk("partial_merged_model", ref_mem[10'h020], 64'h1111_2222_CCCC_DDDD);
    chk("cnt_after_partial", DW'(rmw_cnt), 1);

    // Zero byte enables: granted, no SRAM access
    issue(1'b1, 10'h030, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    issue(1'b0, 10'h030, '0, 8'h00);
    // Read then partial write back-to-back
    issue(1'b0, 10'h010, '0, 8'h00);
    issue(1'b1, 10'h010, 64'h0, 8'hF0);
    issue(1'b0, 10'h010, '0, 8'h00);
    idle(2);
    chk("cnt_directed", DW'(rmw_cnt), DW'(exp_cnt));

    // Randomised mix over a small address window
    for (int n = 0; n < 400; n++) begin
      logic [7:0] be;
      int unsigned sel;
      sel = $urandom_range(0, 3);
      be  = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      issue(1'($urandom), AW'($urandom_range(0, 15)), {$urandom, $urandom}, be);
    end
    idle(2);
    chk("cnt_random", DW'(rmw_cnt), DW'(exp_cnt));

    // Reset during MERGE abandons the write
    old40 = 64'h0BAD_F00D_1234_5678;
    issue(1'b1, 10'h040, old40, 8'hFF);
    idle(1);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 10'h040;
    bus.wdata = 64'h5555_5555_5555_5555; bus.be = 8'h0F;
    chk("pre_rmw_gnt", DW'(bus.gnt), 1);
    exp_reqs++;
    @(posedge clk);
    #1;
    chk("merge_gnt_low", DW'(bus.gnt), 0);
    rst_n = 1'b0;
    bus.req = 1'b0;
    #1;
    chk("rst_mid_gnt", DW'(bus.gnt), 1);
    chk("rst_mid_rvalid", DW'(bus.rvalid), 0);
    chk("rst_mid_cnt", DW'(rmw_cnt), 0);
    chk("rst_mid_sram_req", DW'(sram_req), 0);
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    issue(1'b0, 10'h040, '0, 8'h00);
    idle(2);
    chk("rst_mid_old_model", ref_mem[10'h040], old40);
    chk("cnt_after_reset", DW'(rmw_cnt), 0);

    // Counter saturation
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    idle(1);
    for (int k = 0; k < 3; k++) issue(1'b1, AW'(10'h050 + k), {2{32'h9876_5432}}, 8'h3C);
    idle(2);
    chk("cnt_saturated", DW'(rmw_cnt), DW'(exp_cnt));
    chk("cnt_saturated_const", DW'(rmw_cnt), 64'h0000_0000_FFFF_FFFF);

    idle(3);
    chk("read_queue_drained", DW'(rd_q.size()), 0);
    chk("write_queue_drained", DW'(wr_q.size()), 0);
    chk("sram_req_count", DW'(act_reqs), DW'(exp_reqs));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
